// File: rtl/tt_fsm_pkg.sv
// tt_fsm_pkg: shared cell-state encoding and default timing constants for the button conditioner.
// AUTO_REPEAT_EN adds the hold-counter width and auto-repeat defaults.
package tt_fsm_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_RISE_PEND = 2'b01,
    S_HIGH      = 2'b10,
    S_FALL_PEND = 2'b11
  } cell_state_e;

  localparam int              PRESC_W          = 24;
  localparam int              CNT_W            = 4;
  localparam logic [23:0]     DEF_TICK_DIV     = 24'd10_000;
  localparam int              DEF_STABLE_TICKS = 4;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_W            = 8;
  localparam int DEF_REPEAT_DELAY  = 50;
  localparam int DEF_REPEAT_PERIOD = 10;
`endif

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: one button's debounce FSM, stability count and registered press/release pulses.
// With AUTO_REPEAT_EN a hold counter re-fires press while the accepted level stays high.
module debounce_cell
  import tt_fsm_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_sync,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_TICKS);

  cell_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    state_d   = state_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Leaving a settled state always starts the agreement run at 1.
    count_inc = (state_q == S_LOW || state_q == S_HIGH) ? CNT_W'(1) : count_q + CNT_W'(1);
    if (tick) begin
      case (state_q)
        S_LOW, S_RISE_PEND: begin
          if (btn_sync) begin
            if (count_inc == STABLE) begin
              state_d = S_HIGH;
              count_d = '0;
              press_d = 1'b1;
            end else begin
              state_d = S_RISE_PEND;
              count_d = count_inc;
            end
          end else begin
            state_d = S_LOW;
            count_d = '0;
          end
        end
        S_HIGH, S_FALL_PEND: begin
          if (!btn_sync) begin
            if (count_inc == STABLE) begin
              state_d   = S_LOW;
              count_d   = '0;
              release_d = 1'b1;
            end else begin
              state_d = S_FALL_PEND;
              count_d = count_inc;
            end
          end else begin
            state_d = S_HIGH;
            count_d = '0;
          end
        end
        default: begin
          state_d = S_LOW;
          count_d = '0;
        end
      endcase
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [HOLD_W-1:0] REP_FIRST = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;

  always_comb begin
    hold_d   = hold_q;
    hold_inc = hold_q + HOLD_W'(1);
    repeat_d = 1'b0;
    if (tick) begin
      // Only a tick that stays in S_HIGH counts; any other tick restarts the hold.
      if (state_q == S_HIGH && btn_sync) begin
        if (hold_inc == REP_LAST) begin
          hold_d   = REP_FIRST;
          repeat_d = 1'b1;
        end else begin
          hold_d   = hold_inc;
          repeat_d = (hold_inc == REP_FIRST);
        end
      end else begin
        hold_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`else
  assign repeat_d = 1'b0;
`endif

  // NOTE: reset sits in the sensitivity list, so these flops clear the moment it rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LOW;
      count_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      state_q   <= state_d;
      count_q   <= count_d;
      press_q   <= press_d | repeat_d;
      release_q <= release_d;
    end
  end

  assign level         = (state_q == S_HIGH) || (state_q == S_FALL_PEND);
  assign press         = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/btn_step_conditioner.sv
// btn_step_conditioner: synchronises raw buttons, generates the sample tick and debounces each bit.
// AUTO_REPEAT_EN passes the auto-repeat timing down to every debounce_cell.
module btn_step_conditioner
  import tt_fsm_pkg::*;
#(
  parameter int                 N_BTN        = 8,
  parameter logic [PRESC_W-1:0] TICK_DIV     = DEF_TICK_DIV,
  parameter int                 STABLE_TICKS = DEF_STABLE_TICKS
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press,
  output logic             tick
);

  logic [N_BTN-1:0]   sync1_q, sync1_d;
  logic [N_BTN-1:0]   sync2_q, sync2_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_c;

  assign tick_c = ena && (presc_q == TICK_DIV - PRESC_W'(1));

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    presc_d = presc_q;
    if (ena) presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
  end

  // The synchroniser keeps running with ena low so btn_sync is fresh when ena returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    debounce_cell #(
      .STABLE_TICKS (STABLE_TICKS)
`ifdef AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick_c),
      .btn_sync     (sync2_q[i]),
      .level        (btn_level[i]),
      .press        (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

  assign any_press = |btn_press;
  assign tick      = tick_c;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Scoreboard bench for btn_step_conditioner: a tick-level reference model predicts each pulse
// cycle, a negedge monitor compares DUT pulses, levels and tick against it.
module tb_btn_step_conditioner;

  localparam int N  = 8;
  localparam int TD = 4;
  localparam int ST = 3;
`ifdef AUTO_REPEAT_EN
  localparam int RD = 5;
  localparam int RP = 2;
`endif

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         ena   = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic         any_press, tick;

  always #5 clk = ~clk;

  btn_step_conditioner #(
    .N_BTN       (N),
    .TICK_DIV    (24'(TD)),
    .STABLE_TICKS(ST)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press),
    .tick       (tick)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
  } ev_t;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;

  // Reference model: raw delayed two clocks, then an accepted level that flips after ST
  // consecutive disagreeing sample ticks.
  logic [N-1:0] m_s1    = '0;
  logic [N-1:0] m_s2    = '0;
  logic [N-1:0] m_level = '0;
  int           m_presc = 0;
  int           m_run[N];
  int           m_hold[N];

  int press_cnt[N];
  int any_cnt  = 0;
  int tick_cnt = 0;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_presc = 0;
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      m_hold[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] pr, rl;
    bit           t;
    pr = '0;
    rl = '0;
    cyc++;
    t = ena && (m_presc == TD - 1);
    if (t) begin
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_level[i]) begin
          m_run[i]++;
          m_hold[i] = 0;
          if (m_run[i] == ST) begin
            m_level[i] = m_s2[i];
            m_run[i]   = 0;
            if (m_s2[i]) pr[i] = 1'b1;
            else         rl[i] = 1'b1;
          end
        end else if (m_run[i] != 0) begin
          m_run[i]  = 0;
          m_hold[i] = 0;
        end else if (m_level[i]) begin
          m_hold[i]++;
`ifdef AUTO_REPEAT_EN
          if (m_hold[i] >= RD && (m_hold[i] - RD) % RP == 0) pr[i] = 1'b1;
`endif
        end
      end
    end
    if (ena) m_presc = (m_presc + 1) % TD;
    m_s2 = m_s1;
    m_s1 = btn_raw;
    if ((pr | rl) != '0) exp_q.push_back('{cyc, pr, rl});
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_hold[i] = 0; press_cnt[i] = 0;
    end
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else       model_step();
    end
  end

  // Monitor: pops an expected event whenever the DUT shows a pulse.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      tick_cnt += int'(tick);
      any_cnt  += int'(any_press);
      for (int i = 0; i < N; i++) press_cnt[i] += int'(btn_press[i]);
      check("tick", longint'(tick), longint'(ena && (m_presc == TD - 1)));
      check("level", longint'(btn_level), longint'(m_level));
      if ((btn_press | btn_release) != '0 || any_press) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: actual press=%0h release=%0h, required none (cycle %0d)",
                   btn_press, btn_release, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", longint'(cyc), longint'(e.cyc));
          check("press", longint'(btn_press), longint'(e.pr));
          check("release", longint'(btn_release), longint'(e.rl));
          check("any_press", longint'(any_press), longint'(|e.pr));
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_pulse: actual none, required press=%0h release=%0h at cycle %0d",
                 e.pr, e.rl, e.cyc);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, base2, base_any, base_tick;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ena   = 1'b1;

    base_tick = tick_cnt;
    base_any  = any_cnt;
    cycles(100);
    check("idle_tick_count", tick_cnt - base_tick, 25);
    check("idle_any_press", any_cnt - base_any, 0);

    base = press_cnt[0];
    btn_raw[0] = 1'b1;
    cycles(24);
    check("b0_level_high", btn_level[0], 1);
    check("b0_press_count", press_cnt[0] - base, 1);
    btn_raw[0] = 1'b0;
    cycles(24);
    check("b0_level_low", btn_level[0], 0);

    base = press_cnt[1];
    repeat (5) begin
      btn_raw[1] = 1'b1; cycles(TD);
      btn_raw[1] = 1'b0; cycles(TD);
    end
    cycles(20);
    check("bounce_press_count", press_cnt[1] - base, 0);
    check("bounce_level", btn_level[1], 0);

    base     = press_cnt[2];
    base2    = press_cnt[5];
    base_any = any_cnt;
    btn_raw[2] = 1'b1;
    btn_raw[5] = 1'b1;
    cycles(24);
    check("pair_press2", press_cnt[2] - base, 1);
    check("pair_press5", press_cnt[5] - base2, 1);
    check("pair_any_press", any_cnt - base_any, 1);
    btn_raw[2] = 1'b0;
    btn_raw[5] = 1'b0;
    cycles(24);
    check("pair_levels_low", {btn_level[5], btn_level[2]}, 0);

    base = press_cnt[3];
    btn_raw[3] = 1'b1;
    cycles(6);
    ena       = 1'b0;
    base_tick = tick_cnt;
    cycles(20);
    check("frozen_tick_count", tick_cnt - base_tick, 0);
    check("frozen_level", btn_level[3], 0);
    check("frozen_press_count", press_cnt[3] - base, 0);
    ena = 1'b1;
    cycles(20);
    check("resumed_press_count", press_cnt[3] - base, 1);
    btn_raw[3] = 1'b0;
    cycles(24);

    btn_raw[4] = 1'b1;
    cycles(8);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_outputs", {btn_level, btn_press, btn_release, any_press, tick}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    base  = press_cnt[4];
    cycles(10);
    check("reset_no_early_press", press_cnt[4] - base, 0);
    cycles(16);
    check("reset_press_count", press_cnt[4] - base, 1);
    check("reset_level", btn_level[4], 1);
    btn_raw[4] = 1'b0;
    cycles(24);

    btn_raw[6] = 1'b1;
    cycles(60);
    btn_raw[6] = 1'b0;
    cycles(24);

    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) btn_raw[i] = ~btn_raw[i];
      ena = ($urandom_range(0, 15) != 0);
      cycles(1);
    end

    btn_raw = '0;
    ena     = 1'b1;
    cycles(40);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
